// File: rtl/msx_bank_mapper.sv
// Multi-channel MSX cartridge bank mapper: Z80 slot access -> SDRAM address, one registered cycle.
// Lowest set cs bit selects the channel; bank-register writes are consumed and never reach memory.
module msx_bank_mapper #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 27,
  parameter int BANK_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        cs,
  input  logic [15:0]              cpu_addr,
  input  logic [7:0]               cpu_din,
  input  logic                     cpu_rd,
  input  logic                     cpu_wr,
  input  logic [NUM_CH*5-1:0]      mode,
  input  logic [NUM_CH*ADDR_W-1:0] base,
  input  logic [NUM_CH*16-1:0]     size,
  input  logic [NUM_CH-1:0]        ro,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [7:0]               mem_dout,
  output logic                     hit
);
  localparam logic [4:0] M_NONE  = 5'd3;
  localparam logic [4:0] M_ASC8  = 5'd4;
  localparam logic [4:0] M_ASC16 = 5'd5;
  localparam logic [4:0] M_KON   = 5'd6;
  localparam logic [4:0] M_SCC   = 5'd7;
  localparam logic [4:0] M_LIN   = 5'd9;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MW = (ADDR_W > 30) ? ADDR_W : 30;

  logic [4:0]        mode_a [NUM_CH];
  logic [4:0]        mode_q [NUM_CH];
  logic [ADDR_W-1:0] base_a [NUM_CH];
  logic [15:0]       size_a [NUM_CH];
  logic [BANK_W-1:0] bank   [NUM_CH][4];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign mode_a[g] = mode[g*5 +: 5];
    assign base_a[g] = base[g*ADDR_W +: ADDR_W];
    assign size_a[g] = size[g*16 +: 16];
  end

  function automatic logic [BANK_W-1:0] bank_default(input logic [4:0] m, input logic [1:0] i);
    if (m == M_KON || m == M_SCC) return BANK_W'(i);
    return '0;
  endfunction

  logic              any_sel, mapped, win_ok, in_win, do_rd, do_wr;
  logic              reg_wr, consumed, pair, bank_we, hit_d, rd_d, wr_d;
  logic [CW-1:0]     sel;
  logic [4:0]        sel_mode;
  logic [2:0]        page;
  logic [1:0]        slot, reg_idx;
  logic [ADDR_W-1:0] offset, mask, addr_d;
  logic [MW-1:0]     mask_w;
  logic [BANK_W-1:0] din_b;

  always_comb begin
    any_sel = 1'b0;
    sel     = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (cs[i]) begin
        any_sel = 1'b1;
        sel     = CW'(i);
      end
    end
    sel_mode = mode_a[sel];
    page     = cpu_addr[15:13];
    slot     = 2'(page - 3'd2);
    in_win   = (page >= 3'd2) && (page <= 3'd5);
    do_wr    = cpu_wr;
    do_rd    = cpu_rd & ~cpu_wr;
    din_b    = BANK_W'(cpu_din);
    mapped   = 1'b1;
    win_ok   = in_win;
    offset   = ADDR_W'({bank[sel][slot], cpu_addr[12:0]});
    reg_wr   = 1'b0;
    consumed = 1'b0;
    pair     = 1'b0;
    reg_idx  = slot;
    case (sel_mode)
      M_NONE:  offset = ADDR_W'(cpu_addr - 16'h4000);
      M_LIN: begin
        win_ok = 1'b1;
        offset = ADDR_W'(cpu_addr);
      end
      M_ASC8: begin
        reg_wr  = (page == 3'd3);
        reg_idx = cpu_addr[12:11];
      end
      M_ASC16: begin
        reg_wr  = (cpu_addr[15:11] == 5'b01100) || (cpu_addr[15:11] == 5'b01110);
        pair    = 1'b1;
        reg_idx = {cpu_addr[12], 1'b0};
      end
      // Konami swallows every window write; page 2 is hard-wired to bank 0.
      M_KON: begin
        consumed = 1'b1;
        reg_wr   = (page != 3'd2);
      end
      M_SCC:   reg_wr = (cpu_addr[12:11] == 2'b10);
      default: mapped = 1'b0;
    endcase
    consumed = consumed | reg_wr;
    hit_d    = any_sel & (do_rd | do_wr) & mapped & win_ok;
    bank_we  = hit_d & do_wr & reg_wr;
    rd_d     = hit_d & do_rd;
    wr_d     = hit_d & do_wr & ~consumed & ~ro[sel];
    // size==0 underflows to an all-ones mask, which is exactly the full-range case.
    mask_w   = (MW'(size_a[sel]) << 14) - MW'(1);
    mask     = mask_w[ADDR_W-1:0];
    addr_d   = base_a[sel] + (offset & mask);
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      mode_q[c] <= mode_a[c];
      if (!reset_n || (mode_a[c] != mode_q[c])) begin
        for (int i = 0; i < 4; i++) bank[c][i] <= bank_default(mode_a[c], 2'(i));
      end else if (bank_we && (sel == CW'(c))) begin
        if (pair) begin
          bank[c][reg_idx]        <= {din_b[BANK_W-2:0], 1'b0};
          bank[c][reg_idx | 2'd1] <= {din_b[BANK_W-2:0], 1'b1};
        end else begin
          bank[c][reg_idx] <= din_b;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      hit      <= 1'b0;
    end else begin
      mem_rd <= rd_d;
      mem_wr <= wr_d;
      hit    <= hit_d;
      if (hit_d) mem_addr <= addr_d;
      if (wr_d)  mem_dout <= cpu_din;
    end
  end
endmodule

// File: tb/tb_msx_bank_mapper.sv
// Bench for msx_bank_mapper: directed vector table, hand sequences, then random traffic vs a reference model.
module tb_msx_bank_mapper;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 27;
  localparam int BANK_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cs;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_rd, cpu_wr;
  logic [9:0]  mode;
  logic [53:0] base;
  logic [31:0] size;
  logic [1:0]  ro;
  logic [26:0] mem_addr;
  logic        mem_rd, mem_wr, hit;
  logic [7:0]  mem_dout;

  msx_bank_mapper #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .mode(mode), .base(base), .size(size), .ro(ro),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout), .hit(hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: channel configuration and the bank contents the CPU should see.
  int     cm [2];
  int     pm [2];
  longint cbase [2];
  int     csz [2];
  int     cro [2];
  int     mb [2][4];
  int     e_hit, e_rd, e_wr, e_dout;
  longint e_addr;

  typedef struct {
    logic [1:0]  c;
    logic [15:0] a;
    logic [7:0]  d;
    logic        r, w;
    logic        h, er, ew;
    logic [26:0] ea;
    logic [7:0]  ed;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic load_defaults(input int ch);
    for (int i = 0; i < 4; i++) mb[ch][i] = (cm[ch] == 6 || cm[ch] == 7) ? i : 0;
  endtask

  task automatic model(input logic rst, input logic [1:0] c, input int a, input int d,
                       input logic r, input logic w);
    int ch, m, p, off, s;
    longint msk;
    bit ok, cons;
    e_hit = 0; e_rd = 0; e_wr = 0; e_dout = 0; e_addr = 0;
    if (rst) begin
      ch = c[0] ? 0 : (c[1] ? 1 : -1);
      if (ch >= 0 && (r || w)) begin
        m  = cm[ch];
        p  = a / 8192;
        ok = (m == 3 || m == 4 || m == 5 || m == 6 || m == 7 || m == 9) &&
             (m == 9 || (p >= 2 && p <= 5));
        if (ok) begin
          e_hit = 1;
          if (m == 3)      off = a - 'h4000;
          else if (m == 9) off = a;
          else             off = mb[ch][p-2] * 8192 + a % 8192;
          msk    = (csz[ch] == 0) ? ((64'd1 << 27) - 1) : (longint'(csz[ch]) * 16384 - 1);
          e_addr = (cbase[ch] + (longint'(off) & msk)) % (64'd1 << 27);
          if (w) begin
            cons = 0;
            s    = p - 2;
            if (m == 4 && a >= 'h6000 && a < 'h8000) begin
              cons = 1; mb[ch][(a - 'h6000) / 'h800] = d;
            end else if (m == 5 && a >= 'h6000 && a < 'h6800) begin
              cons = 1; mb[ch][0] = 2 * (d % 128); mb[ch][1] = 2 * (d % 128) + 1;
            end else if (m == 5 && a >= 'h7000 && a < 'h7800) begin
              cons = 1; mb[ch][2] = 2 * (d % 128); mb[ch][3] = 2 * (d % 128) + 1;
            end else if (m == 6) begin
              cons = 1;
              if (s > 0) mb[ch][s] = d;
            end else if (m == 7 && (a % 'h2000) >= 'h1000 && (a % 'h2000) < 'h1800) begin
              cons = 1; mb[ch][s] = d;
            end
            if (!cons && cro[ch] == 0) begin
              e_wr = 1; e_dout = d;
            end
          end else begin
            e_rd = 1;
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst || cm[k] != pm[k]) load_defaults(k);
      pm[k] = cm[k];
    end
  endtask

  task automatic cycle(input logic rst, input logic [1:0] c, input logic [15:0] a,
                       input logic [7:0] d, input logic r, input logic w);
    @(negedge clk);
    reset_n = rst; cs = c; cpu_addr = a; cpu_din = d; cpu_rd = r; cpu_wr = w;
    for (int k = 0; k < 2; k++) begin
      mode[k*5 +: 5]    = 5'(cm[k]);
      base[k*27 +: 27]  = 27'(cbase[k]);
      size[k*16 +: 16]  = 16'(csz[k]);
      ro[k]             = cro[k][0];
    end
    model(rst, c, int'(a), int'(d), r, w);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic h, input logic r, input logic w,
                            input logic [26:0] a, input logic [7:0] d);
    chk({nm, ".hit"}, 64'(hit), 64'(h));
    chk({nm, ".rd"}, 64'(mem_rd), 64'(r));
    chk({nm, ".wr"}, 64'(mem_wr), 64'(w));
    if (r || w) chk({nm, ".addr"}, 64'(mem_addr), 64'(a));
    if (w) chk({nm, ".dout"}, 64'(mem_dout), 64'(d));
  endtask

  task automatic expect_model(input string nm);
    expect_out(nm, e_hit[0], e_rd[0], e_wr[0], 27'(e_addr), 8'(e_dout));
  endtask

  vec_t tbl [10];

  initial begin
    cm[0] = 4; cbase[0] = 'h100000; csz[0] = 8; cro[0] = 0;
    cm[1] = 9; cbase[1] = 'h200000; csz[1] = 0; cro[1] = 0;
    pm = cm;

    tbl[0] = '{2'b01, 16'h4123, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 27'h100123, 8'h00};
    tbl[1] = '{2'b01, 16'h4123, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 27'h000000, 8'h00};
    tbl[2] = '{2'b01, 16'h6800, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 27'h000000, 8'h00};
    tbl[3] = '{2'b01, 16'h6010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 27'h10A010, 8'h00};
    tbl[4] = '{2'b10, 16'h0010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 27'h200010, 8'h00};
    tbl[5] = '{2'b10, 16'hC000, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 27'h20C000, 8'h77};
    tbl[6] = '{2'b01, 16'h3FFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'h000000, 8'h00};
    tbl[7] = '{2'b00, 16'h4000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'h000000, 8'h00};
    tbl[8] = '{2'b11, 16'h4000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 27'h100000, 8'h00};
    tbl[9] = '{2'b01, 16'hA000, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 27'h100000, 8'h12};

    // Reset with a strobe present: everything must come out zero.
    cycle(1'b0, 2'b01, 16'h4000, 8'h00, 1'b1, 1'b0);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 27'h0, 8'h0);
    chk("reset.addr", 64'(mem_addr), 64'h0);
    chk("reset.dout", 64'(mem_dout), 64'h0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].w);
      expect_out($sformatf("vec%0d", i), tbl[i].h, tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].ed);
    end

    // ASCII8 size 64K wrap
    csz[0] = 4;
    cycle(1'b1, 2'b01, 16'h6800, 8'h0F, 1'b0, 1'b1);
    expect_out("a8_wr", 1'b1, 1'b0, 1'b0, 27'h0, 8'h0);
    cycle(1'b1, 2'b01, 16'h6010, 8'h00, 1'b1, 1'b0);
    expect_out("a8_wrap", 1'b1, 1'b1, 1'b0, 27'h10E010, 8'h0);

    // ASCII16 pair write
    cm[0] = 5;
    cycle(1'b1, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 16'h7000, 8'h03, 1'b0, 1'b1);
    expect_out("a16_wr", 1'b1, 1'b0, 1'b0, 27'h0, 8'h0);
    cycle(1'b1, 2'b01, 16'hA001, 8'h00, 1'b1, 1'b0);
    expect_out("a16_b3", 1'b1, 1'b1, 1'b0, 27'h10E001, 8'h0);
    cycle(1'b1, 2'b01, 16'h8000, 8'h00, 1'b1, 1'b0);
    expect_out("a16_b2", 1'b1, 1'b1, 1'b0, 27'h10C000, 8'h0);

    // Konami defaults and ignored page-2 write
    cm[0] = 6;
    cycle(1'b1, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 16'h8000, 8'h00, 1'b1, 1'b0);
    expect_out("kon_def", 1'b1, 1'b1, 1'b0, 27'h104000, 8'h0);
    cycle(1'b1, 2'b01, 16'h4000, 8'h02, 1'b0, 1'b1);
    expect_out("kon_ign", 1'b1, 1'b0, 1'b0, 27'h0, 8'h0);
    cycle(1'b1, 2'b01, 16'h4000, 8'h00, 1'b1, 1'b0);
    expect_out("kon_b0", 1'b1, 1'b1, 1'b0, 27'h100000, 8'h0);
    cycle(1'b1, 2'b01, 16'h8000, 8'h03, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, 16'h8000, 8'h00, 1'b1, 1'b0);
    expect_out("kon_b2", 1'b1, 1'b1, 1'b0, 27'h106000, 8'h0);

    // NONE with read-only on/off
    cm[0] = 3; cro[0] = 1;
    cycle(1'b1, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 16'h4000, 8'h55, 1'b0, 1'b1);
    expect_out("ro_drop", 1'b1, 1'b0, 1'b0, 27'h0, 8'h0);
    cro[0] = 0;
    cycle(1'b1, 2'b01, 16'h4000, 8'h55, 1'b0, 1'b1);
    expect_out("rw_wr", 1'b1, 1'b0, 1'b1, 27'h100000, 8'h55);
    cycle(1'b1, 2'b01, 16'hBFFF, 8'h00, 1'b1, 1'b0);
    expect_out("none_top", 1'b1, 1'b1, 1'b0, 27'h107FFF, 8'h0);
    cycle(1'b1, 2'b01, 16'hC000, 8'h00, 1'b1, 1'b0);
    expect_out("none_out", 1'b0, 1'b0, 1'b0, 27'h0, 8'h0);

    // Unmapped ch0 wins priority over LINEAR ch1
    cm[0] = 0;
    cycle(1'b1, 2'b11, 16'h1234, 8'h00, 1'b1, 1'b0);
    expect_out("prio_unmap", 1'b0, 1'b0, 1'b0, 27'h0, 8'h0);
    cycle(1'b1, 2'b10, 16'h1234, 8'h00, 1'b1, 1'b0);
    expect_out("lin_rd", 1'b1, 1'b1, 1'b0, 27'h201234, 8'h0);

    // Mode change on ch1 restores defaults
    cm[1] = 7;
    cycle(1'b1, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 16'h9000, 8'h09, 1'b0, 1'b1);
    expect_out("scc_wr", 1'b1, 1'b0, 1'b0, 27'h0, 8'h0);
    cycle(1'b1, 2'b10, 16'h8000, 8'h00, 1'b1, 1'b0);
    expect_out("scc_b2", 1'b1, 1'b1, 1'b0, 27'h212000, 8'h0);
    cm[1] = 6;
    cycle(1'b1, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 16'h8000, 8'h00, 1'b1, 1'b0);
    expect_out("mode_reload", 1'b1, 1'b1, 1'b0, 27'h204000, 8'h0);

    // Carry past ADDR_W is discarded
    cm[1] = 9; cbase[1] = 'h7FFF000;
    cycle(1'b1, 2'b10, 16'h2000, 8'h00, 1'b1, 1'b0);
    expect_out("carry", 1'b1, 1'b1, 1'b0, 27'h0001000, 8'h0);

    // 16K image wraps inside one page
    cm[0] = 4; csz[0] = 1;
    cycle(1'b1, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 16'h6800, 8'h05, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, 16'h6010, 8'h00, 1'b1, 1'b0);
    expect_out("wrap16k", 1'b1, 1'b1, 1'b0, 27'h102010, 8'h0);

    // Reset right after an access cancels the output pulse
    cycle(1'b1, 2'b01, 16'h4000, 8'h00, 1'b1, 1'b0);
    expect_out("pre_rst", 1'b1, 1'b1, 1'b0, 27'h100000, 8'h0);
    cycle(1'b0, 2'b01, 16'h4000, 8'h00, 1'b1, 1'b0);
    expect_out("mid_rst", 1'b0, 1'b0, 1'b0, 27'h0, 8'h0);
    chk("mid_rst.addr", 64'(mem_addr), 64'h0);

    // Random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      automatic int k = $urandom_range(0, 1);
      automatic logic [2:0] op = 3'($urandom_range(0, 7));
      automatic logic rst = ($urandom_range(0, 99) != 0);
      automatic int modes [8] = '{0, 3, 4, 5, 6, 7, 9, 8};
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: cm[k] = modes[$urandom_range(0, 7)];
          1: csz[k] = ($urandom_range(0, 3) == 0) ? 0 : (1 << $urandom_range(0, 13));
          2: cbase[k] = longint'($urandom_range(0, 32'h7FFFFFF));
          default: cro[k] = $urandom_range(0, 1);
        endcase
      end
      cycle(rst, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
            8'($urandom_range(0, 255)), op[0] | op[2], op[1]);
      expect_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
